uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised oversampling UART receiver with configurable frame format, input synchroniser, parity/framing/overrun detection and a receive FIFO. Received words leave through a valid/ready stream port. An `rts` flow-control output drops when the FIFO nears full. It replaces the single-rate fixed-format receiver and feeds received words to the BNN input loader.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.
- `OVERSAMPLE`, default 16: `baud_clk` cycles per bit. Even, ≥ 4.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 8: power of two, ≥ 2.
- `RTS_MARGIN`, default 2: `rts` deasserts when free entries ≤ `RTS_MARGIN`.

Ports:
- `baud_clk` in 1: the only clock; runs at `OVERSAMPLE` × bit rate.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx` in 1: asynchronous serial line; idles high.
- `m_data` out `DATA_BITS`: FIFO head word.
- `m_valid` out 1: FIFO not empty.
- `m_ready` in 1: consumer accepts `m_data`.
- `rts` out 1: high = sender may transmit.
- `rx_busy` out 1: frame in progress (state ≠ IDLE).
- `fifo_count` out $clog2(`FIFO_DEPTH`)+1: occupancy.
- `frame_err`, `parity_err`, `overrun_err` out 1 each: sticky error flags.
- `err_clr` in 1: single-cycle pulse clears all sticky flags.

## Operation
- `rx` passes through a 2-flop synchroniser that resets to 1. Call its output `rxs`. All logic uses `rxs`.
- Bit counter `os_cnt` runs 0..`OVERSAMPLE`-1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: when `rxs` = 0, go to START and clear `os_cnt`.
  - START: at `os_cnt` = `OVERSAMPLE`/2−1, sample the line.
    - If `rxs` = 1, this is a false start: go back to IDLE with no flag.
    - Otherwise clear `os_cnt` and go to DATA.
  - DATA: sample at each `os_cnt` = `OVERSAMPLE`−1. Bits arrive LSB first into the shift register. After `DATA_BITS` samples go to PAR if `PARITY` ≠ 0, else to STOP.
  - PAR: one sample. Error if the XOR of data and parity bit is not 0 (even) or not 1 (odd).
  - STOP: `STOP_BITS` samples. Any stop sample of 0 is a framing error.
- On the final stop sample, the FSM returns to IDLE in the same cycle. This allows resync for a start edge that lands in the second half of the stop bit.
- Frame completion outcomes:
  - No error: push the word into the FIFO.
  - Parity error: set `parity_err` and drop the word.
  - Framing error: set `frame_err` and drop the word.
  - Both errors: set both flags.
- Push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise set `overrun_err`, drop the word, and leave the FIFO unchanged.
- FIFO is show-ahead: `m_data` = head entry, `m_valid` = (count ≠ 0). A pop happens when `m_valid` & `m_ready`.
- Simultaneous push and pop leaves `fifo_count` unchanged. Read and write pointers wrap modulo `FIFO_DEPTH`.
- `rts` = (`FIFO_DEPTH` − `fifo_count` > `RTS_MARGIN`). It is registered from the next-state count.
- Sticky flags: a set in the same cycle as `err_clr` takes priority, so the flag stays 1.

## Timing
- Reset values: FSM in IDLE, `os_cnt` 0, synchroniser 1, pointers and `fifo_count` 0.
  - `m_valid` 0, `m_data` 0.
  - `rts` 1, `rx_busy` 0.
  - All error flags 0.
- Reset applied mid-frame aborts the frame; no push and no flag.
- `rxs` lags `rx` by 2 cycles.
- Let T = the first cycle IDLE sees `rxs` = 0. Sample times:
  - Start sample: T + `OVERSAMPLE`/2.
  - Data bit i: T + `OVERSAMPLE`/2 + `OVERSAMPLE`·(i+1).
  - Parity and stop bits follow at the same `OVERSAMPLE` spacing.
- Push happens on the last stop-sample edge. `m_valid` and `fifo_count` update the cycle after.
- For 8N1 with `OVERSAMPLE` = 16: push at T+152, `m_valid` high at T+153.
- Pop: `fifo_count` decrements and `m_data` advances the cycle after the handshake.

## Test plan
- Reset, then 8N1 frame 0xA5 with `m_ready` = 1 → `m_data` = 0xA5 with `m_valid` high for one cycle at T+153. No flags set.
- Low pulse of 6 cycles on `rx` while IDLE → state back to IDLE by T+8. No push, no flag.
- Even-parity config, frame 0x07 with parity bit 0 → word dropped, `parity_err` = 1. Then `err_clr` → flag returns to 0.
- Stop bit forced low on 0x3C → `frame_err` = 1, `fifo_count` stays 0.
- `m_ready` = 0, 9 frames 0x01..0x09 with `FIFO_DEPTH` = 8, `RTS_MARGIN` = 2:
  - `rts` falls after the 6th push.
  - `fifo_count` = 8; the 9th frame sets `overrun_err`.
  - Draining yields 0x01..0x08 in order.
- Assert `rst_n` low in the middle of DATA → after release, `rx_busy` = 0 and `fifo_count` = 0. The next valid frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready stream carrying received words
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with sticky error flags, rts and show-ahead FIFO
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int RTS_MARGIN = 2
) (
  input  logic                        baud_clk,
  input  logic                        rst_n,
  input  logic                        rx,
  uart_rx_fifo_if.master              m,
  output logic                        rts,
  output logic                        rx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun_err,
  input  logic                        err_clr
);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [OW-1:0]        os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rts_q, rts_d, fe_q, fe_d, pe_q, pe_d, oe_q, oe_d;
  logic                 rxs, mid, tick, last, done, bad_stop, push, pop, full, accept;
  assign rxs  = sync_q[1];
  assign mid  = os_cnt_q == OW'(OVERSAMPLE / 2 - 1);
  assign tick = os_cnt_q == OW'(OVERSAMPLE - 1);
  assign last = bit_cnt_q == 4'(state_q == DATA ? DATA_BITS - 1 : STOP_BITS - 1);
  always_ff @(posedge baud_clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rxs) state_d = START;
      START:   if (mid) state_d = rxs ? IDLE : DATA;
      DATA:    if (tick && last) state_d = PARITY != 0 ? PAR : STOP;
      PAR:     if (tick) state_d = STOP;
      STOP:    if (tick && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rx_busy = state_q != IDLE;
  end
  // the last stop sample decides the frame outcome together with the accumulated stop errors
  assign done     = state_q == STOP && tick && last;
  assign bad_stop = ferr_q | ~rxs;
  assign push     = done & ~perr_q & ~bad_stop;
  assign pop      = m.valid & m.ready;
  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign accept   = push & (~full | pop);
  always_comb begin
    sync_d    = {sync_q[0], rx};
    os_cnt_d  = (state_q == IDLE || (state_q == START && mid) || tick) ? '0 : os_cnt_q + 1'b1;
    bit_cnt_d = state_q != state_d ? '0 : tick ? bit_cnt_q + 1'b1 : bit_cnt_q;
    sh_d      = (state_q == DATA && tick) ? {rxs, sh_q[DATA_BITS-1:1]} : sh_q;
    perr_d    = state_q == START ? 1'b0 : (state_q == PAR && tick) ? ((^sh_q ^ rxs) != (PARITY == 2)) : perr_q;
    ferr_d    = state_q == START ? 1'b0 : (state_q == STOP && tick && !rxs) ? 1'b1 : ferr_q;
    mem_d     = mem_q;
    if (accept) mem_d[wptr_q] = sh_q;
    wptr_d    = accept ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d     = cnt_q + CW'(accept) - CW'(pop);
    rts_d     = FIFO_DEPTH - int'(cnt_d) > RTS_MARGIN;
    fe_d      = (done & bad_stop) | (fe_q & ~err_clr);
    pe_d      = (done & perr_q) | (pe_q & ~err_clr);
    oe_d      = (push & ~accept) | (oe_q & ~err_clr);
  end
  always_ff @(posedge baud_clk)
    if (!rst_n) begin
      sync_q    <= 2'b11;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      mem_q     <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rts_q     <= 1'b1;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      rts_q     <= rts_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      oe_q      <= oe_d;
    end
  assign m.data      = mem_q[rptr_q];
  assign m.valid     = cnt_q != '0;
  assign fifo_count  = cnt_q;
  assign rts         = rts_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;
  assign overrun_err = oe_q;
endmodule
